// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush sequencer: stall/bubble/flush are combinational from state and requests,
// pc_redirect/redirect_pc are registered (one cycle after the exception or IF-wait release).
module pipe_hazard_ctrl #(
    parameter int DIV_CYCLES = 33,
    parameter int PC_W       = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_inst_wait,
    input  logic            id_load_use,
    input  logic            ex_div_start,
    input  logic            mem_data_wait,
    input  logic            mem_exception,
    input  logic [PC_W-1:0] mem_exc_target,
    output logic [4:0]      stall,
    output logic [4:0]      bubble,
    output logic            flush,
    output logic            pc_redirect,
    output logic [PC_W-1:0] redirect_pc,
    output logic            div_busy
);

    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DIV        = 2'd1,
        REDIR_WAIT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  div_cnt_q, div_cnt_d;
    logic              lu_done_q, lu_done_d;
    logic              pc_redirect_q, pc_redirect_d;
    logic [PC_W-1:0]   redirect_pc_q, redirect_pc_d;
    logic [PC_W-1:0]   pending_pc_q, pending_pc_d;

    logic [4:0]        stall_c, bubble_c;
    logic              flush_c;
    logic              div_active;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            div_cnt_q     <= '0;
            lu_done_q     <= 1'b0;
            pc_redirect_q <= 1'b0;
            redirect_pc_q <= '0;
            pending_pc_q  <= '0;
        end else begin
            state_q       <= state_d;
            div_cnt_q     <= div_cnt_d;
            lu_done_q     <= lu_done_d;
            pc_redirect_q <= pc_redirect_d;
            redirect_pc_q <= redirect_pc_d;
            pending_pc_q  <= pending_pc_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        div_cnt_d     = div_cnt_q;
        lu_done_d     = lu_done_q;
        pc_redirect_d = 1'b0;
        redirect_pc_d = redirect_pc_q;
        pending_pc_d  = pending_pc_q;
        stall_c       = 5'b00000;
        bubble_c      = 5'b00000;
        flush_c       = 1'b0;
        div_active    = (state_q == DIV) || ((state_q == IDLE) && ex_div_start);

        if (mem_exception) begin
            // Exception squashes everything, including an in-flight divide.
            flush_c   = 1'b1;
            div_cnt_d = '0;
            if (!if_inst_wait) begin
                pc_redirect_d = 1'b1;
                redirect_pc_d = mem_exc_target;
                state_d       = IDLE;
            end else begin
                pending_pc_d  = mem_exc_target;
                state_d       = REDIR_WAIT;
            end
        end else begin
            if (mem_data_wait) begin
                stall_c  = 5'b01111;
                bubble_c = 5'b10000;
            end else if (div_active) begin
                stall_c  = 5'b00111;
                bubble_c = 5'b01000;
            end else if (state_q == REDIR_WAIT) begin
                stall_c  = 5'b00001;
                bubble_c = 5'b00010;
            end else if (id_load_use && !lu_done_q) begin
                stall_c   = 5'b00011;
                bubble_c  = 5'b00100;
                lu_done_d = 1'b1;
            end else if (if_inst_wait) begin
                stall_c  = 5'b00001;
                bubble_c = 5'b00010;
            end

            case (state_q)
                IDLE: begin
                    if (ex_div_start && !mem_data_wait) begin
                        div_cnt_d = CNT_W'(DIV_CYCLES - 1);
                        state_d   = DIV;
                    end
                end
                DIV: begin
                    // The divider keeps counting even while MEM holds the pipe.
                    if (div_cnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        div_cnt_d = div_cnt_q - 1'b1;
                    end
                end
                REDIR_WAIT: begin
                    if (!if_inst_wait) begin
                        pc_redirect_d = 1'b1;
                        redirect_pc_d = pending_pc_q;
                        state_d       = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (!id_load_use) begin
            lu_done_d = 1'b0;
        end
    end

    assign stall       = rst ? 5'b00000 : stall_c;
    assign bubble      = rst ? 5'b00000 : bubble_c;
    assign flush       = rst ? 1'b0 : flush_c;
    assign pc_redirect = pc_redirect_q;
    assign redirect_pc = redirect_pc_q;
    assign div_busy    = (state_q == DIV);

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
- Collects hazard requests: load-use from ID, multi-cycle divide from EX, data-SRAM wait from MEM, inst-SRAM wait from IF, and exception/eret from MEM.
- Drives per-register hold (stall) and bubble (clear) controls plus the PC redirect.
- Runs a small FSM so divides and exception redirects are sequenced without external counters.

Parameters:
- DIV_CYCLES, 33, number of cycles the divider occupies EX after div_start (range 2..63).
- PC_W, 32, width of the PC/redirect target.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- if_inst_wait  in  1  instruction fetch not yet returned.
- id_load_use  in  1  ID instruction needs a load result still in EX.
- ex_div_start  in  1  EX holds a DIV/DIVU; pulse-or-level, sampled only in IDLE.
- mem_data_wait  in  1  data SRAM access in MEM not complete.
- mem_exception  in  1  MEM-stage exception or eret commit.
- mem_exc_target  in  PC_W  handler address or EPC for the redirect.
- stall  out  5  hold enable; bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB.
- bubble  out  5  clear-to-NOP for the same registers (same bit order).
- flush  out  1  synchronous clear of all pipeline registers this cycle.
- pc_redirect  out  1  one-cycle pulse: PC loads redirect_pc.
- redirect_pc  out  PC_W  target valid while pc_redirect=1; otherwise holds its last value.
- div_busy  out  1  high while the divide countdown runs.

Behaviour:
- Reset (async): FSM=IDLE, div_cnt=0, lu_done=0, redirect_pc=0, pending_pc=0. stall=0, bubble=0, flush=0, pc_redirect=0, div_busy=0.
- FSM states: IDLE, DIV, REDIR_WAIT.
- The stall/bubble/flush outputs are combinational from state plus inputs. pc_redirect and redirect_pc are registered.

Priority (highest first) for a given cycle:
1. **mem_exception**
   - flush=1; stall=0; bubble=0.
   - If if_inst_wait=0: next cycle pc_redirect=1, redirect_pc=mem_exc_target, FSM→IDLE. This aborts DIV: div_cnt=0, div_busy=0.
   - If if_inst_wait=1: latch target into pending_pc, FSM→REDIR_WAIT.
2. **mem_data_wait**: stall=5'b01111 (MEM/WB not held), bubble=5'b10000.
3. **DIV state, or IDLE with ex_div_start**: stall=5'b00111, bubble=5'b01000.
4. **id_load_use with lu_done=0**: stall=5'b00011, bubble=5'b00100.
5. **if_inst_wait**: stall=5'b00001, bubble=5'b00010.
6. None of the above: all zero.

Divide sequencing:
- IDLE & ex_div_start & no higher-priority request: div_cnt←DIV_CYCLES-1, FSM→DIV, div_busy=1 from the next cycle.
- DIV: div_cnt decrements each cycle not overridden by exception. Stall continues through the cycle where div_cnt==0.
- When div_cnt==0: FSM→IDLE, div_busy→0; EX/MEM captures the result on that edge.
- mem_data_wait during DIV: the counter keeps decrementing (divider runs independently); the output stall is the union of both patterns (5'b01111).

Load-use:
- lu_done sets on any cycle that issues the load-use stall.
- lu_done clears when id_load_use=0, so a persistent request stalls exactly one cycle. The next load-use on a new instruction stalls again.
- lu_done is unchanged while a higher-priority stall masks the request.

REDIR_WAIT:
- stall=5'b00001; bubble=5'b00010.
- When if_inst_wait falls: pc_redirect=1 next cycle with redirect_pc=pending_pc, FSM→IDLE.
- A new mem_exception in REDIR_WAIT overwrites pending_pc. Last exception wins.

Edge cases:
- Simultaneous ex_div_start and mem_exception: the exception wins and DIV is not entered.
- Reset mid-DIV or mid-REDIR_WAIT: immediate return to reset values; no pc_redirect is emitted.
- pc_redirect is never high for 2 consecutive cycles unless two exceptions arrive on consecutive cycles.

Test Plan:
1. **Reset during DIV:** rst=1 asynchronously at div_cnt=10 → all outputs 0 before the next edge; after release, FSM=IDLE and no redirect.
2. **Divide, DIV_CYCLES=33:** pulse ex_div_start at cycle 0 → stall=5'b00111 and bubble=5'b01000 for exactly 34 cycles (cycles 0..33); div_busy high cycles 1..33; cycle 34 all zero.
3. **Load-use:** id_load_use held 3 cycles → stall=5'b00011 only in the first cycle, zero in the next two; drop and reassert → one more stall cycle.
4. **Exception with IF idle:** mem_exception=1, target=0xBFC00380 → flush=1 that cycle; next cycle pc_redirect=1, redirect_pc=0xBFC00380.
5. **Exception with IF busy:** exception with if_inst_wait=1 held 4 more cycles → REDIR_WAIT with stall=5'b00001 for 4 cycles; pc_redirect pulse one cycle after if_inst_wait falls. A second exception (target 0x80000000) during the wait → redirect_pc=0x80000000.
6. **Divide plus data wait / exception abort:** mem_data_wait during DIV → stall=5'b01111, and div_cnt still reaches 0 on schedule. Exception during DIV → div_busy drops the next cycle and the FSM returns to IDLE.
